// File: rtl/serial_adder_seq_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the sizing helper for the bit counter.
package serial_adder_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Code 2'd3 is deliberately unused; the FSM treats it as a fault and returns to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder assembled from two half adders and an OR gate;
// this is the only arithmetic in the serial adder datapath.
module serial_half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  serial_half_adder u_ha0 (
    .x (x),
    .y (y),
    .s (w_s0),
    .c (w_c0)
  );

  serial_half_adder u_ha1 (
    .x (w_s0),
    .y (ci),
    .s (s),
    .c (w_c1)
  );

  // The two half-adder carries can never both be 1, so OR is an exact carry merge.
  assign co = w_c0 | w_c1;

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: operands are loaded in parallel, then summed
// LSB-first, one bit per clock, through a single full-adder cell.
module serial_adder_seq
  import serial_adder_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int                  LCL_CNT_W = cnt_width(WIDTH);
  localparam logic [LCL_CNT_W-1:0] LAST_BIT = LCL_CNT_W'(WIDTH - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   w_accept;
  logic                   w_last;

  logic [WIDTH-1:0]       r_a_sr;
  logic [WIDTH-1:0]       r_b_sr;
  logic [WIDTH-2:0]       r_sum_sr;
  logic                   r_carry;
  logic [LCL_CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]       r_sum;
  logic                   r_cout;

  logic                   w_s;
  logic                   w_co;
  logic [WIDTH-1:0]       w_sum_next;

  serial_fa_cell u_fa (
    .x  (r_a_sr[0]),
    .y  (r_b_sr[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // r_sum_sr keeps only the bits already produced; the current bit is
  // prepended so the final edge can publish a complete word directly.
  assign w_sum_next = {w_s, r_sum_sr};
  assign w_last     = (r_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S_IDLE;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_SHIFT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        busy         = 1'b1;
        w_next_state = w_last ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_SHIFT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Result registers change only on the final SHIFT edge, so sum/cout stay
  // stable through DONE and any following idle or back-to-back operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_sum_sr <= '0;
      r_carry  <= cin;
      r_cnt    <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_sum_sr <= w_sum_next[WIDTH-1:1];
      r_carry  <= w_co;
      r_cnt    <= r_cnt + LCL_CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_sum_next;
        r_cout <= w_co;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed and randomized checks of the serial adder at WIDTH=8 and WIDTH=5.
module tb_serial_adder_seq;

  logic       clk;
  logic       rst;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start5;
  logic [4:0] a5;
  logic [4:0] b5;
  logic       cin5;
  logic       busy5;
  logic       done5;
  logic [4:0] sum5;
  logic       cout5;

  int checks;
  int failures;

  serial_adder_seq #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_seq #(.WIDTH(5)) dut5 (
    .clk   (clk),
    .rst   (rst),
    .start (start5),
    .a     (a5),
    .b     (b5),
    .cin   (cin5),
    .busy  (busy5),
    .done  (done5),
    .sum   (sum5),
    .cout  (cout5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs are driven and outputs sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input bit use5, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, output int cycles, output int busyCycles,
                        output logic [7:0] rsum, output logic rcout);
    if (use5) begin
      a5 = va[4:0]; b5 = vb[4:0]; cin5 = vc; start5 = 1'b1;
    end else begin
      a8 = va; b8 = vb; cin8 = vc; start8 = 1'b1;
    end
    tick();
    start5 = 1'b0;
    start8 = 1'b0;
    a5 = 5'($urandom); b5 = 5'($urandom); cin5 = 1'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    cycles = 1;
    busyCycles = 0;
    while (cycles <= 40) begin
      if (use5 ? done5 : done8) break;
      if (use5 ? busy5 : busy8) busyCycles++;
      tick();
      cycles++;
    end
    rsum  = use5 ? {3'b000, sum5} : sum8;
    rcout = use5 ? cout5 : cout8;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks += 4;
    if (busy8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy8); end
    if (done8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b, expected 0", done8); end
    if (sum8 !== 8'h00) begin failures++; $display("[TB] FAIL reset_sum: got %h, expected 00", sum8); end
    if (cout8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_cout: got %b, expected 0", cout8); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] va [4] = '{8'h00, 8'hFF, 8'hA5, 8'hA5};
    logic [7:0] vb [4] = '{8'h00, 8'h01, 8'h5A, 8'h5A};
    logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] es [4] = '{8'h00, 8'h00, 8'h00, 8'hFF};
    logic       ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int cycles, busyCycles;
    logic [7:0] rs;
    logic rc;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, va[i], vb[i], vc[i], cycles, busyCycles, rs, rc);
      checks += 4;
      if (cycles !== 9) begin failures++; $display("[TB] FAIL basic%0d_latency: got %0d, expected 9", i, cycles); end
      if (busyCycles !== 8) begin failures++; $display("[TB] FAIL basic%0d_busy: got %0d, expected 8", i, busyCycles); end
      if (rs !== es[i]) begin failures++; $display("[TB] FAIL basic%0d_sum: got %h, expected %h", i, rs, es[i]); end
      if (rc !== ec[i]) begin failures++; $display("[TB] FAIL basic%0d_cout: got %b, expected %b", i, rc, ec[i]); end
      tick();
      checks++;
      if (done8 !== 1'b0) begin failures++; $display("[TB] FAIL basic%0d_done_pulse: got %b, expected 0", i, done8); end
    end
  endtask

  task automatic test_ignore_start();
    int doneCount = 0;
    int doneCycle = 0;
    logic [7:0] rs = 8'h00;
    logic rc = 1'b0;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k == 2) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end else if (k == 3) begin
        start8 = 1'b0;
      end
      if (done8) begin
        doneCount++;
        if (doneCount == 1) begin doneCycle = k + 1; rs = sum8; rc = cout8; end
      end
      tick();
    end
    checks += 5;
    if (doneCount !== 1) begin failures++; $display("[TB] FAIL ignore_done_count: got %0d, expected 1", doneCount); end
    if (doneCycle !== 9) begin failures++; $display("[TB] FAIL ignore_latency: got %0d, expected 9", doneCycle); end
    if (rs !== 8'h46) begin failures++; $display("[TB] FAIL ignore_sum: got %h, expected 46", rs); end
    if (rc !== 1'b0) begin failures++; $display("[TB] FAIL ignore_cout: got %b, expected 0", rc); end
    if (sum8 !== 8'h46) begin failures++; $display("[TB] FAIL ignore_sum_held: got %h, expected 46", sum8); end
  endtask

  task automatic test_back_to_back();
    int doneAt [$];
    int badBusy = 0;
    int badSum = 0;
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (done8) begin
        doneAt.push_back(cyc);
        if (sum8 !== 8'h10 || cout8 !== 1'b0) badSum++;
      end
      if (busy8 === done8) badBusy++;
      tick();
    end
    start8 = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    checks += 3;
    if (doneAt.size() !== 3) begin failures++; $display("[TB] FAIL b2b_done_count: got %0d, expected 3", doneAt.size()); end
    if (badSum !== 0) begin failures++; $display("[TB] FAIL b2b_sum: got %0d bad results, expected 0", badSum); end
    if (badBusy !== 0) begin failures++; $display("[TB] FAIL b2b_busy: got %0d bad cycles, expected 0", badBusy); end
    for (int i = 0; i < doneAt.size() && i < 3; i++) begin
      checks++;
      if (doneAt[i] !== 9 * (i + 1)) begin
        failures++;
        $display("[TB] FAIL b2b_done_pos%0d: got %0d, expected %0d", i, doneAt[i], 9 * (i + 1));
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int strayDone = 0;
    int cycles, busyCycles;
    logic [7:0] rs;
    logic rc;
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    start8 = 1'b1;
    tick();
    checks += 4;
    if (busy8 !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b, expected 0", busy8); end
    if (done8 !== 1'b0) begin failures++; $display("[TB] FAIL midrst_done: got %b, expected 0", done8); end
    if (sum8 !== 8'h00) begin failures++; $display("[TB] FAIL midrst_sum: got %h, expected 00", sum8); end
    if (cout8 !== 1'b0) begin failures++; $display("[TB] FAIL midrst_cout: got %b, expected 0", cout8); end
    rst = 1'b0;
    start8 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done8 || busy8) strayDone++;
      tick();
    end
    checks++;
    if (strayDone !== 0) begin failures++; $display("[TB] FAIL midrst_stray: got %0d active cycles, expected 0", strayDone); end
    run_op(1'b0, 8'h80, 8'h80, 1'b0, cycles, busyCycles, rs, rc);
    checks += 2;
    if (rs !== 8'h00) begin failures++; $display("[TB] FAIL midrst_rerun_sum: got %h, expected 00", rs); end
    if (rc !== 1'b1) begin failures++; $display("[TB] FAIL midrst_rerun_cout: got %b, expected 1", rc); end
    tick();
  endtask

  task automatic test_random_sweep();
    int cycles, busyCycles;
    logic [7:0] rs, va, vb;
    logic rc, vc;
    logic [8:0] expect9;
    logic [5:0] expect6;
    for (int i = 0; i < 1000; i++) begin
      va = 8'($urandom); vb = 8'($urandom); vc = 1'($urandom);
      expect9 = {1'b0, va} + {1'b0, vb} + {8'h00, vc};
      run_op(1'b0, va, vb, vc, cycles, busyCycles, rs, rc);
      checks++;
      if (cycles !== 9 || {rc, rs} !== expect9) begin
        failures++;
        $display("[TB] FAIL rand8_%0d: got %h after %0d cycles, expected %h after 9", i, {rc, rs}, cycles, expect9);
      end
      tick();
      checks++;
      if ({cout8, sum8} !== expect9) begin
        failures++;
        $display("[TB] FAIL rand8_hold_%0d: got %h, expected %h", i, {cout8, sum8}, expect9);
      end
    end
    for (int i = 0; i < 1000; i++) begin
      va = {3'b000, 5'($urandom)}; vb = {3'b000, 5'($urandom)}; vc = 1'($urandom);
      expect6 = {1'b0, va[4:0]} + {1'b0, vb[4:0]} + {5'b00000, vc};
      run_op(1'b1, va, vb, vc, cycles, busyCycles, rs, rc);
      checks++;
      if (cycles !== 6 || {rc, rs[4:0]} !== expect6) begin
        failures++;
        $display("[TB] FAIL rand5_%0d: got %h after %0d cycles, expected %h after 6", i, {rc, rs[4:0]}, cycles, expect6);
      end
      tick();
      checks++;
      if ({cout5, sum5} !== expect6) begin
        failures++;
        $display("[TB] FAIL rand5_hold_%0d: got %h, expected %h", i, {cout5, sum5}, expect6);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start5 = 1'b0; a5 = '0; b5 = '0; cin5 = 1'b0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_shift();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
